// File: rtl/regfile_scoreboard_if.sv
// Register-file / scoreboard bus: read ports, WB write port, issue port and
// the scoreboard status outputs.
//   master: pipeline side (drives addresses, write data, issue)
//   slave : regfile_scoreboard (returns read data, busy flags, busy count)
interface regfile_scoreboard_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] RSaddr_i;
  logic [NUM_RD*DATA_W-1:0] RSdata_o;
  logic [NUM_RD-1:0]        Busy_o;
  logic [ADDR_W-1:0]        RDaddr_i;
  logic [DATA_W-1:0]        RDdata_i;
  logic                     RegWrite_i;
  logic                     Issue_i;
  logic [ADDR_W-1:0]        IssueAddr_i;
  logic [ADDR_W:0]          BusyCnt_o;

  modport master (
    output RSaddr_i, RDaddr_i, RDdata_i, RegWrite_i, Issue_i, IssueAddr_i,
    input  RSdata_o, Busy_o, BusyCnt_o
  );

  modport slave (
    input  RSaddr_i, RDaddr_i, RDdata_i, RegWrite_i, Issue_i, IssueAddr_i,
    output RSdata_o, Busy_o, BusyCnt_o
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with NUM_RD combinational read ports, one clocked write port,
// optional write->read bypass, optional hardwired-zero r0, and a per-register
// busy scoreboard with a registered busy count for the hazard unit.
// Ports:
//   clk_i  - clock, all state updates on the rising edge
//   rst_i  - asynchronous active-high reset (clears registers and scoreboard)
//   bus    - regfile_scoreboard_if.slave: RSaddr_i/RSdata_o/Busy_o read side,
//            RDaddr_i/RDdata_i/RegWrite_i write side, Issue_i/IssueAddr_i,
//            BusyCnt_o
module regfile_scoreboard #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  regfile_scoreboard_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0]        regs [DEPTH];
  logic [DEPTH-1:0]         busy_q;
  logic [DEPTH-1:0]         busy_d;
  logic [CNT_W-1:0]         busy_cnt_q;
  logic [CNT_W-1:0]         busy_cnt_d;
  logic                     wr_ok;
  logic                     sb_set;
  logic                     sb_clr;
  logic                     cnt_inc;
  logic                     cnt_dec;
  logic [ADDR_W-1:0]        rd_addr;
  logic [NUM_RD*DATA_W-1:0] rs_data;
  logic [NUM_RD-1:0]        busy_rd;

  // Write and scoreboard qualifiers; r0 is protected only when hardwired.
  always_comb begin
    wr_ok  = bus.RegWrite_i & ~((ZERO_REG != 0) & (bus.RDaddr_i == '0));
    sb_set = bus.Issue_i & ~((ZERO_REG != 0) & (bus.IssueAddr_i == '0));
    sb_clr = bus.RegWrite_i;
  end

  // Next busy vector: set is applied after clear so a same-address issue wins.
  // The count tracks actual 0->1 / 1->0 transitions so it never drifts.
  always_comb begin
    busy_d = busy_q;
    if (sb_clr) busy_d[bus.RDaddr_i] = 1'b0;
    if (sb_set) busy_d[bus.IssueAddr_i] = 1'b1;

    cnt_inc = sb_set & ~busy_q[bus.IssueAddr_i];
    cnt_dec = sb_clr & busy_q[bus.RDaddr_i]
            & ~(sb_set & (bus.IssueAddr_i == bus.RDaddr_i));

    busy_cnt_d = busy_cnt_q;
    if (cnt_inc & ~cnt_dec)      busy_cnt_d = busy_cnt_q + CNT_W'(1);
    else if (cnt_dec & ~cnt_inc) busy_cnt_d = busy_cnt_q - CNT_W'(1);
  end

  // Register array write port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[bus.RDaddr_i] <= bus.RDdata_i;
    end
  end

  // Scoreboard state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Read ports: zero register, then bypass, then array. A forwarded source
  // is reported not-busy since its value is available this cycle.
  always_comb begin
    rs_data = '0;
    busy_rd = '0;
    rd_addr = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      rd_addr = bus.RSaddr_i[k*ADDR_W +: ADDR_W];
      if ((ZERO_REG != 0) && (rd_addr == '0)) begin
        rs_data[k*DATA_W +: DATA_W] = '0;
        busy_rd[k]                  = 1'b0;
      end else begin
        if ((BYPASS != 0) && wr_ok && (bus.RDaddr_i == rd_addr))
          rs_data[k*DATA_W +: DATA_W] = bus.RDdata_i;
        else
          rs_data[k*DATA_W +: DATA_W] = regs[rd_addr];

        if ((BYPASS != 0) && sb_clr && (bus.RDaddr_i == rd_addr))
          busy_rd[k] = 1'b0;
        else
          busy_rd[k] = busy_q[rd_addr];
      end
    end
  end

  assign bus.RSdata_o  = rs_data;
  assign bus.Busy_o    = busy_rd;
  assign bus.BusyCnt_o = busy_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Drives two register files in lockstep (r0 hardwired + bypass, and plain
// r0 + no bypass) and checks every cycle against an array-based model.
module tb_regfile_scoreboard;

  logic clk;
  logic rst;

  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus_a ();
  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus_b ();

  regfile_scoreboard #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .bus(bus_a.slave)
  );

  regfile_scoreboard #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)
  ) u_nb (
    .clk_i(clk), .rst_i(rst), .bus(bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [63:0] data_a;
    logic [1:0]  busy_a;
    logic [5:0]  cnt_a;
    logic [63:0] data_b;
    logic [1:0]  busy_b;
    logic [5:0]  cnt_b;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   step_id = 0;

  // Reference model: index 0 = ZERO_REG/BYPASS config, 1 = plain config.
  logic [31:0] mem [2][32];
  bit          bsy [2][32];

  function automatic void model_reset();
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 32; r++) begin
        mem[c][r] = 32'h0;
        bsy[c][r] = 1'b0;
      end
  endfunction

  function automatic void predict(input int c, input logic [4:0] a0, input logic [4:0] a1,
                                  input bit we, input logic [4:0] rd, input logic [31:0] wd,
                                  output logic [63:0] d, output logic [1:0] b,
                                  output logic [5:0] n);
    bit          zero;
    bit          byp;
    bit          wr_ok;
    logic [4:0]  a;
    int          cnt;
    zero  = (c == 0);
    byp   = (c == 0);
    wr_ok = we && !(zero && rd == 5'd0);
    d = '0;
    b = '0;
    for (int k = 0; k < 2; k++) begin
      a = (k == 0) ? a0 : a1;
      if (zero && a == 5'd0) begin
        d[k*32 +: 32] = 32'h0;
        b[k] = 1'b0;
      end else begin
        d[k*32 +: 32] = (byp && wr_ok && rd == a) ? wd : mem[c][a];
        b[k] = (byp && we && rd == a) ? 1'b0 : bsy[c][a];
      end
    end
    cnt = 0;
    for (int r = 0; r < 32; r++) cnt += int'(bsy[c][r]);
    n = 6'(cnt);
  endfunction

  function automatic void commit(input int c, input bit we, input logic [4:0] rd,
                                 input logic [31:0] wd, input bit iss, input logic [4:0] ia);
    bit zero;
    zero = (c == 0);
    if (we && !(zero && rd == 5'd0)) mem[c][rd] = wd;
    if (we) bsy[c][rd] = 1'b0;
    if (iss && !(zero && ia == 5'd0)) bsy[c][ia] = 1'b1;
  endfunction

  function automatic void check(input int id, input string what,
                                input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL step %0d %s: got %h expected %h", id, what, act, exp);
    end
  endfunction

  // One cycle of stimulus: drive at posedge+1, predict, then advance the model
  // at the next edge. r=1 raises reset between edges.
  task automatic step(input bit r, input logic [4:0] a0, input logic [4:0] a1,
                      input bit we_in, input logic [4:0] rd, input logic [31:0] wd,
                      input bit iss_in, input logic [4:0] ia);
    exp_t e;
    bit   we;
    bit   iss;
    we  = r ? 1'b0 : we_in;
    iss = r ? 1'b0 : iss_in;
    rst = r;
    bus_a.RSaddr_i = {a1, a0};   bus_b.RSaddr_i = {a1, a0};
    bus_a.RegWrite_i = we;       bus_b.RegWrite_i = we;
    bus_a.RDaddr_i = rd;         bus_b.RDaddr_i = rd;
    bus_a.RDdata_i = wd;         bus_b.RDdata_i = wd;
    bus_a.Issue_i = iss;         bus_b.Issue_i = iss;
    bus_a.IssueAddr_i = ia;      bus_b.IssueAddr_i = ia;
    if (r) model_reset();
    e.id = step_id;
    predict(0, a0, a1, we, rd, wd, e.data_a, e.busy_a, e.cnt_a);
    predict(1, a0, a1, we, rd, wd, e.data_b, e.busy_b, e.cnt_b);
    exp_q.push_back(e);
    @(posedge clk);
    if (r) model_reset();
    else begin
      commit(0, we, rd, wd, iss, ia);
      commit(1, we, rd, wd, iss, ia);
    end
    step_id++;
    #1;
  endtask

  // Monitor: compares whatever the DUTs present mid-cycle against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.id, "a_rsdata",  64'(bus_a.RSdata_o),  e.data_a);
      check(e.id, "a_busy",    64'(bus_a.Busy_o),    64'(e.busy_a));
      check(e.id, "a_busycnt", 64'(bus_a.BusyCnt_o), 64'(e.cnt_a));
      check(e.id, "b_rsdata",  64'(bus_b.RSdata_o),  e.data_b);
      check(e.id, "b_busy",    64'(bus_b.Busy_o),    64'(e.busy_b));
      check(e.id, "b_busycnt", 64'(bus_b.BusyCnt_o), 64'(e.cnt_b));
    end
  end

  initial begin
    rst = 1'b1;
    bus_a.RSaddr_i = '0; bus_a.RegWrite_i = 1'b0; bus_a.RDaddr_i = '0;
    bus_a.RDdata_i = '0; bus_a.Issue_i = 1'b0;    bus_a.IssueAddr_i = '0;
    bus_b.RSaddr_i = '0; bus_b.RegWrite_i = 1'b0; bus_b.RDaddr_i = '0;
    bus_b.RDdata_i = '0; bus_b.Issue_i = 1'b0;    bus_b.IssueAddr_i = '0;
    model_reset();
    @(posedge clk); #1;

    // Reset held, then release.
    step(1, 5'd0, 5'd1, 0, 5'd0, 32'h0, 0, 5'd0);
    step(1, 5'd0, 5'd1, 0, 5'd0, 32'h0, 0, 5'd0);

    // r5 = DEADBEEF with a same-cycle issue of r5, then async reset mid-cycle.
    step(0, 5'd5, 5'd5, 1, 5'd5, 32'hDEADBEEF, 1, 5'd5);
    step(0, 5'd5, 5'd5, 0, 5'd0, 32'h0, 1, 5'd8);
    step(1, 5'd5, 5'd8, 0, 5'd0, 32'h0, 0, 5'd0);
    step(0, 5'd5, 5'd8, 0, 5'd0, 32'h0, 0, 5'd0);

    // Write/read, including the r0 write.
    step(0, 5'd0, 5'd0, 1, 5'd3, 32'h12345678, 0, 5'd0);
    step(0, 5'd3, 5'd3, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 32'h0, 0, 5'd0);

    // Bypass vs. no bypass on r7.
    step(0, 5'd7, 5'd3, 1, 5'd7, 32'h11111111, 0, 5'd0);
    step(0, 5'd7, 5'd3, 1, 5'd7, 32'hA5A5A5A5, 0, 5'd0);
    step(0, 5'd7, 5'd7, 0, 5'd0, 32'h0, 0, 5'd0);

    // Scoreboard on r9.
    step(0, 5'd9, 5'd1, 0, 5'd0, 32'h0, 1, 5'd9);
    step(0, 5'd9, 5'd9, 0, 5'd0, 32'h0, 0, 5'd0);
    step(0, 5'd9, 5'd9, 1, 5'd9, 32'h99, 0, 5'd0);
    step(0, 5'd9, 5'd9, 0, 5'd0, 32'h0, 0, 5'd0);

    // Simultaneous set/clear: same address, then different addresses.
    step(0, 5'd4, 5'd6, 0, 5'd0, 32'h0, 1, 5'd4);
    step(0, 5'd4, 5'd6, 1, 5'd4, 32'h44, 1, 5'd4);
    step(0, 5'd4, 5'd6, 1, 5'd4, 32'h45, 1, 5'd6);
    step(0, 5'd4, 5'd6, 0, 5'd0, 32'h0, 0, 5'd0);
    step(0, 5'd4, 5'd6, 1, 5'd6, 32'h66, 0, 5'd0);

    // Count bounds: fill all nonzero registers, issue r0, drain, over-drain.
    for (int i = 1; i < 32; i++) step(0, 5'(i), 5'd0, 0, 5'd0, 32'h0, 1, 5'(i));
    step(0, 5'd31, 5'd0, 0, 5'd0, 32'h0, 1, 5'd0);
    step(0, 5'd31, 5'd0, 0, 5'd0, 32'h0, 0, 5'd0);
    for (int i = 1; i < 32; i++) step(0, 5'(i), 5'(i), 1, 5'(i), 32'(i * 3), 0, 5'd0);
    step(0, 5'd1, 5'd0, 1, 5'd0, 32'h0, 0, 5'd0);
    for (int i = 1; i < 4; i++) step(0, 5'(i), 5'd0, 1, 5'(i), 32'h7, 0, 5'd0);
    step(0, 5'd1, 5'd2, 0, 5'd0, 32'h0, 0, 5'd0);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), 32'($urandom),
           ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)));
    end

    step(0, 5'd0, 5'd1, 0, 5'd0, 32'h0, 0, 5'd0);
    @(posedge clk); #1;
    check(-1, "queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor register file for the pipelined CPU, sitting in the ID stage.
- Provides NUM_RD combinational read ports and one clocked write port (WB stage).
- Read-after-write bypass is optional; register 0 can be hardwired to zero.
- A per-register busy scoreboard marks registers with an outstanding producer, which the hazard unit uses for stall decisions.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2, number of read ports.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- RSaddr_i  input  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- RSdata_o  output  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
- Busy_o  output  NUM_RD  bit k = source register of port k has an outstanding producer.
- RDaddr_i  input  ADDR_W  write address.
- RDdata_i  input  DATA_W  write data.
- RegWrite_i  input  1  write enable; also clears the busy bit of RDaddr_i.
- Issue_i  input  1  an instruction with destination IssueAddr_i issued this cycle.
- IssueAddr_i  input  ADDR_W  destination register of the issued instruction.
- BusyCnt_o  output  ADDR_W+1  number of registers currently busy.

Behaviour:
- Reset:
  - While rst_i is high, asynchronously and regardless of clk_i: all DEPTH registers = 0, all busy bits = 0, busy count = 0.
  - Consequently RSdata_o = 0, Busy_o = 0 and BusyCnt_o = 0 during and immediately after reset.
  - Reset asserted mid-write discards that write.
- Writable condition: wr_ok = RegWrite_i & ~(ZERO_REG & RDaddr_i == 0).
- Write:
  - On the rising edge with wr_ok, register[RDaddr_i] <= RDdata_i.
  - Writes take effect one cycle after presentation (latency 1).
- Read (combinational, zero latency) for each port k:
  - If ZERO_REG and addr_k == 0: 0.
  - Else if BYPASS and wr_ok and RDaddr_i == addr_k: RDdata_i.
  - Else: register[addr_k].
  - With BYPASS = 0, a read of the address being written returns the old value until the edge.
  - Multiple ports reading the same address all see identical data.
- Scoreboard:
  - set = Issue_i & ~(ZERO_REG & IssueAddr_i == 0).
  - clr = RegWrite_i (the busy bit is cleared even if the write itself is blocked for register 0).
  - On the edge: busy[IssueAddr_i] <= 1 if set; busy[RDaddr_i] <= 0 if clr.
  - Set and clear on the same address in the same cycle: set wins (a new producer issued while the old one writes back), and the bit stays 1.
  - Issue to an already-busy register is legal; the bit stays 1 and the next writeback to that address clears it (one outstanding producer tracked per register).
  - Clear of a non-busy register has no effect.
- Busy_o[k] = busy[addr_k], masked to 0 when:
  - ZERO_REG and addr_k == 0; or
  - BYPASS and clr and RDaddr_i == addr_k (the value is being forwarded this cycle).
- BusyCnt_o:
  - Registered; always equals the popcount of the busy bits (0..DEPTH), with no wrap.
  - Per edge it is incremented only if a 0->1 transition occurs and decremented only if a 1->0 transition occurs.
  - Simultaneous set of one address and clear of a different busy address leaves it unchanged.
- Unknown or X addresses are not required to be handled.

Test Plan:
- Reset: assert rst_i asynchronously between edges after writing r5 = 0xDEADBEEF -> RSdata_o for r5 = 0, Busy_o = 0 and BusyCnt_o = 0 immediately, without waiting for a clock edge.
- Write/read: write r3 = 0x12345678 -> following cycle, both ports reading r3 return 0x12345678; write r0 = 0xFFFFFFFF with ZERO_REG = 1 -> r0 reads 0.
- Bypass: port 0 reads r7 while RegWrite_i writes r7 = 0xA5A5A5A5 -> same cycle, RSdata_o port 0 = 0xA5A5A5A5; with BYPASS = 0 it returns the old value until the edge.
- Scoreboard: issue r9 -> next cycle Busy_o = 1 for port reading r9 and BusyCnt_o = 1; writeback r9 -> Busy_o masked 0 in that cycle (BYPASS = 1), BusyCnt_o = 0 after the edge.
- Simultaneous events: r4 busy, then issue r4 while writing back r4 -> r4 remains busy, BusyCnt_o unchanged; issue r6 while writing back r4 -> BusyCnt_o unchanged, r6 busy, r4 clear.
- Count bounds: issue all 31 nonzero registers back-to-back -> BusyCnt_o = 31; issue r0 -> no change; write back all 31 -> BusyCnt_o = 0, never negative.
